// File: rtl/decimal_keypad_debouncer.sv
// Debounced front end for ten decimal keys. Raw key lines are synchronised,
// filtered so that only one clean key is ever presented, and driven out as a
// registered one-hot vector with press/release strobes and a multi-key flag.
module decimal_keypad_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] key_raw,
    output logic [9:0] key_onehot,
    output logic       key_valid,
    output logic       key_release,
    output logic       multi_err
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DB_PRESS,
        PRESSED,
        DB_RELEASE
    } state_t;

    // Synchronised key vector (second flop of each per-bit chain)
    logic [9:0] s;

    genvar gi;
    generate
        for (gi = 0; gi < 10; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;

            // Two-flop synchroniser for one asynchronous key line
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= key_raw[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign s[gi] = sync_reg;
        end
    endgenerate

    // Classification: clearing the lowest set bit leaves something only when
    // two or more keys are down.
    logic       s_any;
    logic       s_multi;
    logic       s_single;
    logic [9:0] s_low_cleared;

    assign s_low_cleared = s & (s - 10'd1);
    assign s_any         = |s;
    assign s_multi       = s_any && (s_low_cleared != 10'd0);
    assign s_single      = s_any && !s_multi;

    state_t           state_reg, state_next;
    logic [9:0]       cand_reg, cand_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [9:0]       onehot_reg, onehot_next;
    logic             valid_reg, valid_next;
    logic             release_reg, release_next;
    logic             prev_multi_reg;
    logic             multi_err_reg;

    // State register and all FSM-owned output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            cand_reg    <= 10'd0;
            cnt_reg     <= '0;
            onehot_reg  <= 10'd0;
            valid_reg   <= 1'b0;
            release_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cand_reg    <= cand_next;
            cnt_reg     <= cnt_next;
            onehot_reg  <= onehot_next;
            valid_reg   <= valid_next;
            release_reg <= release_next;
        end
    end

    // Next-state logic: accept a single key after a stable run, and release it
    // only once every key is up for a stable run (no rollover).
    always_comb begin
        state_next   = state_reg;
        cand_next    = cand_reg;
        cnt_next     = cnt_reg;
        onehot_next  = onehot_reg;
        valid_next   = 1'b0;
        release_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (s_single) begin
                    cand_next  = s;
                    cnt_next   = '0;
                    state_next = DB_PRESS;
                end
            end

            DB_PRESS: begin
                if (s == cand_reg) begin
                    if (cnt_reg == CNT_LAST) begin
                        state_next  = PRESSED;
                        onehot_next = cand_reg;
                        valid_next  = 1'b1;
                        cnt_next    = '0;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end else begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            end

            PRESSED: begin
                if (s != cand_reg) begin
                    state_next = DB_RELEASE;
                    cnt_next   = '0;
                end
            end

            DB_RELEASE: begin
                if (!s_any) begin
                    if (cnt_reg == CNT_LAST) begin
                        state_next   = IDLE;
                        onehot_next  = 10'd0;
                        release_next = 1'b1;
                        cnt_next     = '0;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end else if (s == cand_reg) begin
                    // Release bounce: the same key came back
                    state_next = PRESSED;
                    cnt_next   = '0;
                end else begin
                    // Some other key is down; wait for all keys up
                    cnt_next = '0;
                end
            end

            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Multi-key detector: pulse on the rising edge of "two or more keys"
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_multi_reg <= 1'b0;
            multi_err_reg  <= 1'b0;
        end else begin
            prev_multi_reg <= s_multi;
            multi_err_reg  <= s_multi && !prev_multi_reg;
        end
    end

    assign key_onehot  = onehot_reg;
    assign key_valid   = valid_reg;
    assign key_release = release_reg;
    assign multi_err   = multi_err_reg;

endmodule

// File: doc/decimal_keypad_debouncer.md
Name: decimal_keypad_debouncer

Overview:
- Front-end stage for the decimal encoder. Takes ten raw, asynchronous, bouncy decimal key lines (keys 0–9).
- Synchronises and debounces them, and allows only a single clean key.
- Drives a registered one-hot 10-bit vector that connects directly to the encoder's 10-bit decimal one-hot input.
- Guarantees the downstream encoder sees only all-zero or exactly-one-hot values, plus press/release strobes.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable synchronised cycles required to accept a press or a release. Legal range is 1 or more.
- CNT_W (localparam), $clog2(DEBOUNCE_CYCLES+1): width of the debounce counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- key_raw  input  10  raw key lines. Bit i high means key i is pressed. Asynchronous to clk.
- key_onehot  output  10  debounced key. Exactly one bit is set while a key is accepted; otherwise 0. Registered.
- key_valid  output  1  one-cycle pulse in the first cycle that key_onehot becomes non-zero.
- key_release  output  1  one-cycle pulse in the first cycle that key_onehot returns to 0.
- multi_err  output  1  one-cycle pulse when the synchronised input goes from not-multi to multi (two or more bits set).

Behaviour:
- Reset (asynchronous, immediate):
  - key_onehot=0, key_valid=0, key_release=0, multi_err=0.
  - Both synchroniser stages = 0, counter = 0, cand = 0, state = IDLE.
- Synchroniser: two-flop chain per bit. s = second stage. All logic below uses s only.
- Classification of s: NONE (s==0), SINGLE (exactly one bit set), MULTI (two or more bits set).
- FSM states and transitions (evaluated on each rising edge):
  - IDLE:
    - SINGLE: cand<=s, cnt<=0, go to DB_PRESS.
    - NONE or MULTI: stay in IDLE.
  - DB_PRESS:
    - s==cand and cnt==DEBOUNCE_CYCLES-1: go to PRESSED, key_onehot<=cand, key_valid pulses.
    - s==cand otherwise: cnt++.
    - s!=cand (glitch, other key, or multi): go to IDLE, cnt<=0, no output change.
  - PRESSED:
    - key_onehot is held at cand.
    - s!=cand: go to DB_RELEASE, cnt<=0.
  - DB_RELEASE:
    - s==0 and cnt==DEBOUNCE_CYCLES-1: go to IDLE, key_onehot<=0, key_release pulses.
    - s==0 otherwise: cnt++.
    - s==cand: return to PRESSED (bounce), no pulse.
    - s is any other non-zero value: cnt<=0, stay in DB_RELEASE. No rollover: all keys must be released before a new key can register.
- Latency:
  - Edge 0 is the first rising edge that samples a stable change on key_raw.
  - key_valid (or key_release) is high in the cycle after edge DEBOUNCE_CYCLES+2.
- key_onehot never holds more than one set bit. key_valid and key_release are never asserted in the same cycle.
- multi_err:
  - A flop records whether the previous s was MULTI. multi_err = (s is MULTI) and not(previous s was MULTI), registered.
  - Independent of FSM state. Does not change state beyond the transitions above.
- Reset mid-operation: outputs clear at once. A key still held after reset deassertion must be debounced again from scratch and produces a new key_valid.
- Counter saturation: cnt never exceeds DEBOUNCE_CYCLES-1. It is cleared on every state entry.

Test Plan:
1. Clean press, DEBOUNCE_CYCLES=4. key_raw=0x020 held steady -> key_valid is a single pulse after edge 6; key_onehot=0x020 from that cycle onward; multi_err stays 0.
2. Press bounce, N=4. key_raw toggles 0x008/0x000 with 2-cycle highs three times, then holds 0x008 -> no key_valid during the bounce; exactly one key_valid 6 edges after the hold begins; key_onehot=0x008.
3. Release bounce, N=4. From PRESSED with key 0x008: release, re-press for 2 cycles, release and hold 0 -> key_onehot stays 0x008 during the glitch; exactly one key_release, 6 edges after the final release; key_onehot=0.
4. Multi-key, N=4. key_raw=0x081 from IDLE -> multi_err is one pulse 2 edges later; key_valid never asserts; key_onehot stays 0. Then change to 0x001 -> normal accept, key_onehot=0x001.
5. Rollover, N=4. Accept key 2 (0x004), then raw=0x084, then raw=0x080 -> multi_err pulses; key_onehot stays 0x004; no key_valid for key 7. Raw=0 for 4+ cycles -> key_release; key_onehot=0.
6. Reset mid-press, N=4. Assert rst while key_onehot=0x200 with the key still held -> all outputs 0 asynchronously. After rst deasserts with raw still 0x200 -> key_valid after the 7th rising edge following deassertion; key_onehot=0x200.
